// File: rtl/fft_stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : fft_stage_sequencer_pkg
// Brief  : Sequencer state type and butterfly address helper.
// Rev    : 1.0
// ============================================================================
package fft_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_seq_state_t;

    // Opens a gap at bit 'pos' by shifting the upper part of k left by one.
    function automatic logic [31:0] insert_bit(input logic [31:0] k,
                                               input logic [31:0] pos,
                                               input logic        val);
        logic [31:0] mask;
        mask = (32'd1 << pos) - 32'd1;
        return ((k & ~mask) << 1) | (32'(val) << pos) | (k & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_stage_sequencer_addr_fifo.sv
`default_nettype none
// ============================================================================
// Module : fft_addr_fifo
// Brief  : Writeback address FIFO with occupancy count and flop-array head.
// Rev    : 1.0
// ============================================================================
module fft_addr_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full is the count MSB because DEPTH is a power of two; a push while
    // full is only legal when the head leaves in the same cycle.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && (!r_count[c_aw] || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_count <= r_count + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fft_stage_sequencer
// Brief  : Stage-by-stage address and start sequencer for an in-place FFT.
// Rev    : 1.0
// ============================================================================
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int LOG_N      = 10,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      use_ct,
    output logic                      rd_en,
    output logic [LOG_N-1:0]          rd_addr_a,
    output logic [LOG_N-1:0]          rd_addr_b,
    output logic [LOG_N-2:0]          tw_addr,
    output logic                      bfly_start,
    output logic                      use_ct_out,
    input  logic                      bfly_done,
    output logic                      wr_en,
    output logic [LOG_N-1:0]          wr_addr_a,
    output logic [LOG_N-1:0]          wr_addr_b,
    output logic [$clog2(LOG_N)-1:0]  stage,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int c_kw = LOG_N - 1;
    localparam int c_sw = $clog2(LOG_N);
    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    fft_seq_state_t    r_state;
    logic [c_kw-1:0]   r_k;
    logic [c_sw-1:0]   r_stage;
    logic              r_use_ct;
    logic              r_rd_en;
    logic              r_bfly_start;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [LOG_N-1:0]  r_rd_a;
    logic [LOG_N-1:0]  r_rd_b;
    logic [LOG_N-1:0]  r_push_a;
    logic [LOG_N-1:0]  r_push_b;
    logic [c_kw-1:0]   r_tw;

    logic [31:0]       w_h;
    logic [31:0]       w_sh;
    logic [LOG_N-1:0]  w_a;
    logic [LOG_N-1:0]  w_b;
    logic [c_kw-1:0]   w_j;
    logic [c_kw-1:0]   w_tw;
    logic [2*LOG_N-1:0] w_head;
    logic [c_cw-1:0]   w_count;
    logic              w_empty;
    logic              w_pop;
    logic              w_room;
    logic              w_pipe_idle;
    logic              w_last_k;
    logic              w_last_stage;

    // GS shrinks the half-span each stage while CT grows it; the twiddle
    // stride moves the opposite way so the index always spans N/2 entries.
    always_comb begin
        w_h  = r_use_ct ? 32'(r_stage) : 32'(c_kw) - 32'(r_stage);
        w_sh = r_use_ct ? 32'(c_kw) - 32'(r_stage) : 32'(r_stage);
        w_a  = LOG_N'(insert_bit(32'(r_k), w_h, 1'b0));
        w_b  = w_a | LOG_N'(32'd1 << w_h);
        w_j  = c_kw'(32'(r_k) & ((32'd1 << w_h) - 32'd1));
        w_tw = c_kw'(32'(w_j) << w_sh);
    end

    // Reads in the RAM pipeline are not yet in the FIFO but already own a slot.
    assign w_room       = (32'(w_count) + 32'(r_rd_en) + 32'(r_bfly_start)) < 32'(FIFO_DEPTH);
    assign w_pipe_idle  = w_empty && !r_rd_en && !r_bfly_start;
    assign w_last_k     = &r_k;
    assign w_last_stage = (r_stage == c_sw'(c_kw));
    assign w_pop        = bfly_done && !w_empty;

    fft_addr_fifo #(
        .WIDTH (2*LOG_N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_bfly_start),
        .push_data ({r_push_a, r_push_b}),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_stage      <= '0;
            r_use_ct     <= 1'b0;
            r_rd_en      <= 1'b0;
            r_bfly_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_rd_a       <= '0;
            r_rd_b       <= '0;
            r_push_a     <= '0;
            r_push_b     <= '0;
            r_tw         <= '0;
        end else begin
            r_bfly_start <= r_rd_en;
            r_push_a     <= r_rd_a;
            r_push_b     <= r_rd_b;
            r_rd_en      <= 1'b0;
            r_done       <= 1'b0;
            if (bfly_done && w_empty) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_use_ct <= use_ct;
                        r_stage  <= '0;
                        r_k      <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_room) begin
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_a;
                        r_rd_b  <= w_b;
                        r_tw    <= w_tw;
                        r_k     <= r_k + c_kw'(1);
                        if (w_last_k) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Next stage reads only after every result of this one is written.
                    if (w_pipe_idle) begin
                        if (w_last_stage) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_stage <= r_stage + c_sw'(1);
                            r_k     <= '0;
                            r_state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_en      = r_rd_en;
    assign rd_addr_a  = r_rd_a;
    assign rd_addr_b  = r_rd_b;
    assign tw_addr    = r_tw;
    assign bfly_start = r_bfly_start;
    assign use_ct_out = r_use_ct;
    assign wr_en      = w_pop;
    assign wr_addr_a  = w_head[2*LOG_N-1:LOG_N];
    assign wr_addr_b  = w_head[LOG_N-1:0];
    assign stage      = r_stage;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_stage_sequencer
// Brief  : Scoreboard bench: 8-point unit (hand tables) and 16-point stall unit.
// Rev    : 1.0
// ============================================================================
module tb_fft_stage_sequencer;

    typedef struct { int a; int b; int tw; int st; } rd_exp_t;
    typedef struct { int a; int b; } wr_exp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic use_ct = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic bd0    = 1'b0;
    logic bd1    = 1'b0;
    logic stray  = 1'b0;

    logic       rd_en0, bfly_start0, use_ct_out0, wr_en0, busy0, done0, err0;
    logic [2:0] rd_a0, rd_b0, wr_a0, wr_b0;
    logic [1:0] tw0, stage0;
    logic       rd_en1, bfly_start1, use_ct_out1, wr_en1, busy1, done1, err1;
    logic [3:0] rd_a1, rd_b1, wr_a1, wr_b1;
    logic [2:0] tw1;
    logic [1:0] stage1;

    rd_exp_t rdq[$];
    wr_exp_t wrq[$];
    rd_exp_t e;
    wr_exp_t w;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 5;
    logic [63:0] sch0 = '0;
    logic [63:0] sch1 = '0;
    int issued = 0, written = 0, done_cnt = 0, stall_cnt = 0;
    int cyc = 0, last_cyc = 0, last_st = -1;
    logic prev_rd [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    fft_stage_sequencer #(.LOG_N(3), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .use_ct(use_ct),
        .rd_en(rd_en0), .rd_addr_a(rd_a0), .rd_addr_b(rd_b0), .tw_addr(tw0),
        .bfly_start(bfly_start0), .use_ct_out(use_ct_out0), .bfly_done(bd0),
        .wr_en(wr_en0), .wr_addr_a(wr_a0), .wr_addr_b(wr_b0), .stage(stage0),
        .busy(busy0), .done(done0), .err(err0)
    );

    fft_stage_sequencer #(.LOG_N(4), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .use_ct(use_ct),
        .rd_en(rd_en1), .rd_addr_a(rd_a1), .rd_addr_b(rd_b1), .tw_addr(tw1),
        .bfly_start(bfly_start1), .use_ct_out(use_ct_out1), .bfly_done(bd1),
        .wr_en(wr_en1), .wr_addr_a(wr_a1), .wr_addr_b(wr_b1), .stage(stage1),
        .busy(busy1), .done(done1), .err(err1)
    );

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Butterfly model: done follows each start by 'lat' cycles, flushed by reset.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            sch0 = '0;
            sch1 = '0;
        end else begin
            sch0 = {sch0[62:0], bfly_start0};
            sch1 = {sch1[62:0], bfly_start1};
        end
        bd0 = sch0[lat];
        bd1 = sch1[lat] | stray;
    end

    // Monitor: pops expectations whenever either unit presents a read or write.
    logic rd, bs, wr, dn;
    int   ra, rb, tw, st, wa, wb, depth, half;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_rd[0] = 1'b0;
            prev_rd[1] = 1'b0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                rd = (u == 0) ? rd_en0 : rd_en1;
                bs = (u == 0) ? bfly_start0 : bfly_start1;
                wr = (u == 0) ? wr_en0 : wr_en1;
                dn = (u == 0) ? done0 : done1;
                ra = (u == 0) ? int'(rd_a0) : int'(rd_a1);
                rb = (u == 0) ? int'(rd_b0) : int'(rd_b1);
                tw = (u == 0) ? int'(tw0) : int'(tw1);
                st = (u == 0) ? int'(stage0) : int'(stage1);
                wa = (u == 0) ? int'(wr_a0) : int'(wr_a1);
                wb = (u == 0) ? int'(wr_b0) : int'(wr_b1);
                half  = (u == 0) ? 4 : 8;
                depth = 4;
                check(bs == prev_rd[u], "bfly_start_follows_rd_en", int'(bs), int'(prev_rd[u]));
                prev_rd[u] = rd;
                if (rd) begin
                    issued++;
                    if (st == last_st && cyc != last_cyc + 1) stall_cnt++;
                    last_st  = st;
                    last_cyc = cyc;
                    check(issued - written <= depth, "outstanding_le_depth", issued - written, depth);
                    check(written >= st * half, "stage_after_prior_writes", written, st * half);
                    if (rdq.size() == 0) begin
                        check(1'b0, "rd_unexpected", ra, -1);
                    end else begin
                        e = rdq.pop_front();
                        check(ra == e.a, "rd_addr_a", ra, e.a);
                        check(rb == e.b, "rd_addr_b", rb, e.b);
                        check(tw == e.tw, "tw_addr", tw, e.tw);
                        check(st == e.st, "stage", st, e.st);
                    end
                end
                if (wr) begin
                    written++;
                    if (wrq.size() == 0) begin
                        check(1'b0, "wr_unexpected", wa, -1);
                    end else begin
                        w = wrq.pop_front();
                        check(wa == w.a, "wr_addr_a", wa, w.a);
                        check(wb == w.b, "wr_addr_b", wb, w.b);
                    end
                end
                if (dn) done_cnt++;
            end
        end
    end

    // Hand-computed 8-point orderings.
    int gs_a[12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int gs_b[12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int gs_t[12] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};
    int ct_a[12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    int ct_b[12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    int ct_t[12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};

    task automatic push_exp(input int a, input int b, input int t, input int s);
        rd_exp_t re;
        wr_exp_t we;
        re.a = a; re.b = b; re.tw = t; re.st = s;
        we.a = a; we.b = b;
        rdq.push_back(re);
        wrq.push_back(we);
    endtask

    task automatic push_table(input bit ct);
        for (int i = 0; i < 12; i++) begin
            if (ct) push_exp(ct_a[i], ct_b[i], ct_t[i], i / 4);
            else    push_exp(gs_a[i], gs_b[i], gs_t[i], i / 4);
        end
    endtask

    // 16-point ordering built group-by-group from the butterfly span.
    task automatic push_model(input bit ct);
        int span;
        for (int s = 0; s < 4; s++) begin
            span = ct ? (1 << s) : (16 >> (s + 1));
            for (int g = 0; g < 16; g += 2 * span) begin
                for (int i = 0; i < span; i++) begin
                    push_exp(g + i, g + i + span, (ct ? (i << (3 - s)) : (i << s)) & 7, s);
                end
            end
        end
    endtask

    task automatic run(input int u, input bit ct, input int l, input bit poke);
        int to;
        lat = l; issued = 0; written = 0; done_cnt = 0; stall_cnt = 0; last_st = -1;
        if (u == 0) push_table(ct);
        else        push_model(ct);
        use_ct = ct;
        if (u == 0) start0 = 1'b1;
        else        start1 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0; use_ct = ~ct;
        check(((u == 0) ? busy0 : busy1) == 1'b1, "busy_after_start", 0, 1);
        check(((u == 0) ? use_ct_out0 : use_ct_out1) == ct, "use_ct_out_latched", int'(~ct), int'(ct));
        if (poke) begin
            repeat (3) tick();
            if (u == 0) start0 = 1'b1;
            else        start1 = 1'b1;
            tick();
            start0 = 1'b0; start1 = 1'b0;
            check(((u == 0) ? use_ct_out0 : use_ct_out1) == ct, "use_ct_out_hold", int'(~ct), int'(ct));
        end
        to = 0;
        while (done_cnt == 0 && to < 3000) begin
            tick();
            to++;
        end
        tick();
        check(done_cnt == 1, "done_once", done_cnt, 1);
        check(((u == 0) ? busy0 : busy1) == 1'b0, "busy_cleared", 1, 0);
        check(rdq.size() == 0, "rd_left", rdq.size(), 0);
        check(wrq.size() == 0, "wr_left", wrq.size(), 0);
        if (u == 0) check(stall_cnt == 0, "no_stall", stall_cnt, 0);
        else        check(stall_cnt > 0, "stall_seen", stall_cnt, 1);
        rdq.delete();
        wrq.delete();
    endtask

    initial begin
        int to;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check((rd_en0 | bfly_start0 | busy0 | done0 | err0 | use_ct_out0 | wr_en0) == 1'b0,
              "reset_flags_u0", 1, 0);
        check(stage0 == 2'd0, "reset_stage_u0", int'(stage0), 0);
        check((rd_en1 | bfly_start1 | busy1 | done1 | err1 | use_ct_out1 | wr_en1) == 1'b0,
              "reset_flags_u1", 1, 0);
        check(stage1 == 2'd0, "reset_stage_u1", int'(stage1), 0);

        run(0, 1'b0, 5, 1'b0);
        run(0, 1'b1, 5, 1'b1);
        run(0, 1'b0, 1, 1'b0);
        run(1, 1'b0, 10, 1'b0);
        run(1, 1'b1, 10, 1'b0);

        // Abort in the middle of stage 1 issue.
        lat = 10; issued = 0; written = 0; done_cnt = 0; last_st = -1;
        push_model(1'b0);
        use_ct = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        to = 0;
        while (!(stage1 == 2'd1 && rd_en1) && to < 500) begin
            tick();
            to++;
        end
        check(stage1 == 2'd1 && rd_en1, "reach_stage1_issue", int'(stage1), 1);
        rst = 1'b1;
        tick();
        check(busy1 == 1'b0, "rst_busy", int'(busy1), 0);
        check(rd_en1 == 1'b0, "rst_rd_en", int'(rd_en1), 0);
        check(stage1 == 2'd0, "rst_stage", int'(stage1), 0);
        rst = 1'b0;
        rdq.delete();
        wrq.delete();
        repeat (12) tick();
        check(err1 == 1'b0, "err_quiet_after_rst", int'(err1), 0);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        check(wr_en1 == 1'b0, "stray_no_write", int'(wr_en1), 0);
        tick();
        check(err1 == 1'b1, "err_set_by_stray", int'(err1), 1);
        repeat (5) tick();
        check(err1 == 1'b1, "err_sticky", int'(err1), 1);

        run(1, 1'b0, 10, 1'b0);
        check(err1 == 1'b1, "err_sticky_after_run", int'(err1), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check(err1 == 1'b0, "err_cleared_by_rst", int'(err1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Controller that feeds the FFT butterfly datapath. For each stage it generates operand and twiddle read addresses for a single-port-pair coefficient RAM and issues butterfly start pulses.
- It tracks in-flight butterflies and produces writeback addresses aligned with the butterfly done pulse.
- It sits between the coefficient/twiddle memories and the butterfly, and runs a full in-place N-point transform, either Gentleman-Sande (GS) or Cooley-Tukey (CT) ordering.

Parameters:
- LOG_N, 10, log2 of transform size N; N/2 butterflies per stage, LOG_N stages.
- FIFO_DEPTH, 32, writeback address FIFO entries; must be power of two and at least butterfly latency + 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a transform when idle.
- use_ct  in  1  sampled at start; 1 = CT ordering, 0 = GS ordering; held internally for the whole run and driven out on use_ct_out.
- rd_en  out  1  memory read strobe for operands and twiddle.
- rd_addr_a  out  LOG_N  index of butterfly a operand.
- rd_addr_b  out  LOG_N  index of butterfly b operand.
- tw_addr  out  LOG_N-1  twiddle table index (N/2-entry table).
- bfly_start  out  1  butterfly start; asserted exactly 1 cycle after the corresponding rd_en (1-cycle RAM read latency).
- use_ct_out  out  1  latched mode to the butterfly.
- bfly_done  in  1  butterfly done pulse, one per issued start, in issue order.
- wr_en  out  1  writeback strobe, combinationally equal to bfly_done and FIFO not empty.
- wr_addr_a  out  LOG_N  writeback index for a result (FIFO head).
- wr_addr_b  out  LOG_N  writeback index for b result (FIFO head).
- stage  out  $clog2(LOG_N)  current stage number.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last writeback of the last stage.
- err  out  1  sticky: bfly_done received with the FIFO empty; cleared only by rst.

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. rst mid-run aborts immediately; bfly_done pulses after reset with an empty FIFO set err.
- FSM IDLE: start latches use_ct, sets stage=0 and k=0, then goes to ISSUE. start while not IDLE is ignored.
- FSM ISSUE: each cycle with FIFO count + pending < FIFO_DEPTH, assert rd_en and push {a,b} into the FIFO.
  - The FIFO push is delayed 1 cycle together with bfly_start, so FIFO push equals bfly_start.
  - Increment k. After k = N/2-1 is issued, go to DRAIN.
  - If the FIFO is full, rd_en stays low (stall); no address is skipped.
- FSM DRAIN: wait until the FIFO is empty and no issue is pending.
  - Write of the last butterfly completes in the same cycle the FIFO empties.
  - If stage < LOG_N-1: stage++, k=0, go to ISSUE in the next cycle. This serialization resolves inter-stage RAW hazards.
  - Else go to DONE.
- FSM DONE: pulse done for 1 cycle, then go to IDLE.
- Address generation for butterfly index k (LOG_N-1 bits):
  - h = half-span log2: GS h = LOG_N-1-stage; CT h = stage.
  - a = k with a 0 bit inserted at bit position h; b = a | (1<<h).
  - j = k mod 2^h.
  - tw_addr = j << sh, where GS sh = stage and CT sh = LOG_N-1-stage, truncated to LOG_N-1 bits.
- FIFO: simultaneous push and pop is allowed at any count, including full, with the count unchanged. Pop is on bfly_done only. Write addresses are the registered head, valid in the same cycle as bfly_done.
- Throughput: 1 butterfly per cycle in ISSUE when not stalled. Stage overhead is the butterfly latency plus 2 cycles.

Decomposition:
- Shared package: state enum fft_seq_state_t {IDLE, ISSUE, DRAIN, DONE}.
- Shared package: function insert_bit(k, pos, val) for address generation.
- One sub-module: fft_addr_fifo, a synchronous FIFO with count, registered head, and simultaneous push/pop support.

Test Plan:
- LOG_N=3, GS, butterfly model latency 5:
  - stage0 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3.
  - stage1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2.
  - stage2 reads (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0.
  - wr addresses match the reads, delayed by 6 cycles; done pulses once.
- LOG_N=3, CT:
  - stage0 reads (0,1),(2,3),(4,5),(6,7) with tw 0.
  - stage1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2.
  - stage2 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3.
- FIFO_DEPTH=4, latency 10: rd_en stalls after 4 issues; no address is dropped or duplicated; stage never advances before the last wr_en of the prior stage.
- start asserted while busy: ignored; use_ct_out is unchanged mid-run.
- rst asserted in stage1 ISSUE: next cycle busy=0, rd_en=0, FIFO empty; a later stray bfly_done sets err=1, which stays set until rst.
- bfly_start always follows rd_en by exactly 1 cycle; a back-to-back start after done runs a second clean transform.
